cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_pkg.sv | 26 ++
 rtl/cp0_req_arb.sv | 25 ++
 rtl/cp0_ctrl.sv | 128 ++++++++++++
 tb/tb_cp0_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, ExcCodes, handler entry point and
// the EPC derivation used when an exception or interrupt is taken.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] raw;
    raw = bd ? (pc - 32'd4) : pc;
    return {raw[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Exception/interrupt request arbiter: decides whether M is redirected to the
// handler and which ExcCode is recorded. Interrupts win over sync exceptions.
module cp0_req_arb
  import cp0_pkg::*;
(
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hwint,
  input  logic [4:0] m_exc,
  output logic       req,
  output logic [4:0] exc_code
);

  logic int_pend;
  logic exc_pend;

  always_comb begin
    int_pend = ie & ~exl & (|(im & hwint));
    exc_pend = (m_exc != EXC_INT) & ~exl;
    req      = int_pend | exc_pend;
    exc_code = int_pend ? EXC_INT : m_exc;
  end

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 control block: SR, Cause, EPC, PRId, exception entry and eret return.
// Optional BadVAddr (reg 8) and m_badaddr port enabled by CP0_BADVADDR_EN.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h2004_0701
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exc,
  input  logic        m_eret,
  input  logic [5:0]  hwint,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] m_badaddr,
`endif
  output logic [31:0] dout,
  output logic        req,
  output logic [31:0] epc_out
);

  logic [5:0]  sr_im_q,    sr_im_d;
  logic        sr_exl_q,   sr_exl_d;
  logic        sr_ie_q,    sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q,      epc_d;
  logic [4:0]  exc_code;
  logic [31:0] badvaddr_rd;

  cp0_req_arb u_arb (
    .ie       (sr_ie_q),
    .exl      (sr_exl_q),
    .im       (sr_im_q),
    .hwint    (hwint),
    .m_exc    (m_exc),
    .req      (req),
    .exc_code (exc_code)
  );

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hwint;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req) begin
      // Exception entry owns the registers; a same-cycle mtc0 is dropped.
      sr_exl_d    = 1'b1;
      cause_bd_d  = m_bd;
      cause_exc_d = exc_code;
      epc_d       = exc_epc(m_pc, m_bd);
    end else begin
      if (m_eret) sr_exl_d = 1'b0;
      if (we) begin
        case (addr)
          REG_SR: begin
            sr_im_d  = din[15:10];
            sr_exl_d = din[1];
            sr_ie_d  = din[0];
          end
          REG_EPC: epc_d = {din[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q, badvaddr_d;

  always_comb begin
    badvaddr_d = badvaddr_q;
    if (req && (exc_code == EXC_ADEL || exc_code == EXC_ADES)) badvaddr_d = m_badaddr;
  end

  always_ff @(posedge clk) begin
    if (reset) badvaddr_q <= '0;
    else       badvaddr_q <= badvaddr_d;
  end

  assign badvaddr_rd = badvaddr_q;
`else
  assign badvaddr_rd = '0;
`endif

  always_comb begin
    dout = '0;
    case (addr)
      REG_BADVADDR: dout = badvaddr_rd;
      REG_SR:       dout = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
      REG_CAUSE:    dout = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b00};
      REG_EPC:      dout = epc_q;
      REG_PRID:     dout = PRID_VALUE;
      default:      dout = '0;
    endcase
  end

  assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: directed cycles push expected req/dout/epc_out,
// a monitor on the falling edge pops and compares.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc;
  logic        m_eret;
  logic [5:0]  hwint;
`ifdef CP0_BADVADDR_EN
  logic [31:0] m_badaddr = '0;
`endif
  logic [31:0] dout;
  logic        req;
  logic [31:0] epc_out;

  localparam logic [31:0] PRID = 32'h2004_0701;

  cp0_ctrl #(.PRID_VALUE(PRID)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .m_pc      (m_pc),
    .m_bd      (m_bd),
    .m_exc     (m_exc),
    .m_eret    (m_eret),
    .hwint     (hwint),
`ifdef CP0_BADVADDR_EN
    .m_badaddr (m_badaddr),
`endif
    .dout      (dout),
    .req       (req),
    .epc_out   (epc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          ck_req;
    logic        req;
    bit          ck_dout;
    logic [31:0] dout;
    bit          ck_epc;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Drive one cycle's inputs shortly after the rising edge.
  task automatic cyc(input logic rs, input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [31:0] pc, input logic bd,
                     input logic [4:0] exc, input logic er, input logic [5:0] hw);
    @(posedge clk);
    #1;
    reset = rs; we = w; addr = a; din = d; m_pc = pc; m_bd = bd;
    m_exc = exc; m_eret = er; hwint = hw;
  endtask

  task automatic idle(input logic [4:0] a, input logic [5:0] hw);
    cyc(1'b0, 1'b0, a, 32'h0, 32'h0000_3000, 1'b0, 5'd0, 1'b0, hw);
  endtask

  task automatic expect_cyc(input string nm, input bit cr, input logic r,
                            input bit cd, input logic [31:0] d,
                            input bit ce, input logic [31:0] e);
    exp_t x;
    x.name = nm; x.ck_req = cr; x.req = r; x.ck_dout = cd; x.dout = d;
    x.ck_epc = ce; x.epc = e;
    sb.push_back(x);
  endtask

  // Monitor: one expectation per cycle at most, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.ck_req) begin
          n_vec++;
          if (req !== e.req) begin
            n_bad++;
            $display("FAIL %s req: got %0b expected %0b", e.name, req, e.req);
          end
        end
        if (e.ck_dout) begin
          n_vec++;
          if (dout !== e.dout) begin
            n_bad++;
            $display("FAIL %s dout: got %08h expected %08h", e.name, dout, e.dout);
          end
        end
        if (e.ck_epc) begin
          n_vec++;
          if (epc_out !== e.epc) begin
            n_bad++;
            $display("FAIL %s epc_out: got %08h expected %08h", e.name, epc_out, e.epc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; din = '0; m_pc = '0; m_bd = 1'b0;
    m_exc = '0; m_eret = 1'b0; hwint = '0;
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0);

    // Reset state
    idle(5'd12, 6'd0); expect_cyc("rst_sr",    1, 1'b0, 1, 32'h0, 1, 32'h0);
    idle(5'd13, 6'd0); expect_cyc("rst_cause", 0, 1'b0, 1, 32'h0, 0, 32'h0);
    idle(5'd14, 6'd0); expect_cyc("rst_epc",   0, 1'b0, 1, 32'h0, 0, 32'h0);
    idle(5'd15, 6'd0); expect_cyc("prid",      0, 1'b0, 1, PRID,  0, 32'h0);
    idle(5'd8,  6'd0); expect_cyc("badvaddr0", 0, 1'b0, 1, 32'h0, 0, 32'h0);

    // Interrupt entry: IM bit 10, IE
    cyc(1'b0, 1'b1, 5'd12, 32'h0000_0401, 32'h3000, 1'b0, 5'd0, 1'b0, 6'd0);
    expect_cyc("wr_sr", 1, 1'b0, 0, 32'h0, 0, 32'h0);
    idle(5'd12, 6'd0); expect_cyc("rd_sr", 1, 1'b0, 1, 32'h0000_0401, 0, 32'h0);
    cyc(1'b0, 1'b0, 5'd12, 32'h0, 32'h3010, 1'b0, 5'd0, 1'b0, 6'b000001);
    expect_cyc("int_req", 1, 1'b1, 0, 32'h0, 1, 32'h0);
    idle(5'd13, 6'd0); expect_cyc("int_cause", 1, 1'b0, 1, 32'h0000_0400, 1, 32'h0000_3010);
    idle(5'd12, 6'd0); expect_cyc("int_sr_exl", 1, 1'b0, 1, 32'h0000_0403, 0, 32'h0);

    // IP latches while EXL=1, no request
    cyc(1'b0, 1'b0, 5'd12, 32'h0, 32'h3014, 1'b0, 5'd0, 1'b0, 6'b100000);
    expect_cyc("ip_exl_noreq", 1, 1'b0, 0, 32'h0, 0, 32'h0);
    idle(5'd13, 6'd0); expect_cyc("ip_exl_latch", 0, 1'b0, 1, 32'h0000_8000, 0, 32'h0);

    // Exception masked by EXL, then eret
    cyc(1'b0, 1'b0, 5'd14, 32'h0, 32'h5000, 1'b0, 5'd4, 1'b0, 6'd0);
    expect_cyc("exl_mask", 1, 1'b0, 1, 32'h0000_3010, 1, 32'h0000_3010);
    idle(5'd14, 6'd0); expect_cyc("exl_epc_hold", 0, 1'b0, 1, 32'h0000_3010, 1, 32'h0000_3010);
    cyc(1'b0, 1'b0, 5'd12, 32'h0, 32'h3018, 1'b0, 5'd0, 1'b1, 6'd0);
    expect_cyc("eret_req", 1, 1'b0, 1, 32'h0000_0403, 0, 32'h0);
    idle(5'd12, 6'd0); expect_cyc("eret_clr", 1, 1'b0, 1, 32'h0000_0401, 0, 32'h0);

    // Overflow in delay slot
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 32'h3024, 1'b1, 5'd12, 1'b0, 6'd0);
    expect_cyc("ov_req", 1, 1'b1, 0, 32'h0, 0, 32'h0);
    idle(5'd13, 6'd0); expect_cyc("ov_cause", 1, 1'b0, 1, 32'h8000_0030, 1, 32'h0000_3020);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 32'h3028, 1'b0, 5'd0, 1'b1, 6'd0);
    expect_cyc("ov_eret", 1, 1'b0, 0, 32'h0, 0, 32'h0);

    // RI plus interrupt: interrupt wins
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 32'h3100, 1'b0, 5'd10, 1'b0, 6'b000001);
    expect_cyc("prio_req", 1, 1'b1, 0, 32'h0, 0, 32'h0);
    idle(5'd13, 6'd0); expect_cyc("prio_cause", 0, 1'b0, 1, 32'h0000_0400, 1, 32'h0000_3100);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 32'h3104, 1'b0, 5'd0, 1'b1, 6'd0);
    expect_cyc("prio_eret", 1, 1'b0, 0, 32'h0, 0, 32'h0);

    // mtc0 EPC: low bits forced, visible next cycle
    cyc(1'b0, 1'b1, 5'd14, 32'h0000_3047, 32'h3108, 1'b0, 5'd0, 1'b0, 6'd0);
    expect_cyc("epc_wr", 1, 1'b0, 1, 32'h0000_3100, 1, 32'h0000_3100);
    idle(5'd14, 6'd0); expect_cyc("epc_wr_vis", 0, 1'b0, 1, 32'h0000_3044, 1, 32'h0000_3044);
    cyc(1'b0, 1'b1, 5'd14, 32'h0000_3047, 32'h3200, 1'b0, 5'd12, 1'b0, 6'd0);
    expect_cyc("epc_wr_req", 1, 1'b1, 1, 32'h0000_3044, 0, 32'h0);
    idle(5'd14, 6'd0); expect_cyc("epc_wr_supp", 0, 1'b0, 1, 32'h0000_3200, 1, 32'h0000_3200);

    // Writes to Cause and PRId ignored; SR write masked to IM/EXL/IE
    cyc(1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 32'h3204, 1'b0, 5'd0, 1'b0, 6'd0);
    cyc(1'b0, 1'b1, 5'd15, 32'hFFFF_FFFF, 32'h3208, 1'b0, 5'd0, 1'b0, 6'd0);
    expect_cyc("cause_ro", 0, 1'b0, 1, PRID, 0, 32'h0);
    idle(5'd13, 6'd0); expect_cyc("cause_keep", 0, 1'b0, 1, 32'h0000_0030, 0, 32'h0);
    cyc(1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h320c, 1'b0, 5'd0, 1'b0, 6'd0);
    idle(5'd12, 6'd0); expect_cyc("sr_mask", 1, 1'b0, 1, 32'h0000_FC03, 0, 32'h0);

    // Reset overrides a live request, mtc0 and eret
    cyc(1'b0, 1'b1, 5'd12, 32'h0000_0401, 32'h3300, 1'b0, 5'd0, 1'b0, 6'd0);
    cyc(1'b1, 1'b1, 5'd14, 32'h0000_1234, 32'h3300, 1'b0, 5'd12, 1'b1, 6'd0);
    expect_cyc("rst_req_live", 1, 1'b1, 0, 32'h0, 0, 32'h0);
    idle(5'd12, 6'd0); expect_cyc("rst2_sr",    1, 1'b0, 1, 32'h0, 1, 32'h0);
    idle(5'd13, 6'd0); expect_cyc("rst2_cause", 0, 1'b0, 1, 32'h0, 0, 32'h0);
    idle(5'd14, 6'd0); expect_cyc("rst2_epc",   0, 1'b0, 1, 32'h0, 0, 32'h0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
